nmk112_pcm_arbiter: RTL and testbench
=====================================

Name: nmk112_pcm_arbiter

Overview:
- Parametrised successor to the single-chip NMK112 mapper used on the Raizing sound boards.
- Serves CHANNELS jt6295 ADPCM engines from one shared SDRAM PCM port.
- Each channel has its own four NMK112-style bank registers, with optional table-region paging.
- Includes a round-robin fetch arbiter and per-channel data latches with ok flags; sits between the jt6295 instances and the PCM_* SDRAM slot.

Parameters:
- CHANNELS, 2, number of ADPCM engines served (1..4).
- BANK_W, 5, bank register width; ROM_AW = BANK_W+16.
- PAGE_MASK, 1, bitmask of channels using table-region paging; ignored unless NMK112_PAGING_EN is defined.

Ports:
- CLK96  in  1  system clock
- RESET96_N  in  1  reset: asynchronous, active-low
- BANK_WE  in  1  bank register write strobe, one cycle
- BANK_SEL  in  4  {channel[1:0], bank[1:0]}
- BANK_DIN  in  8  bank value; low BANK_W bits used
- REQ_CS  in  CHANNELS  per-channel fetch enable
- REQ_ADDR  in  CHANNELS*18  per-channel jt6295 rom_addr
- REQ_DATA  out  CHANNELS*8  per-channel latched byte
- REQ_OK  out  CHANNELS  per-channel data valid for current REQ_ADDR
- ROM_CS  out  1  SDRAM request
- ROM_ADDR  out  BANK_W+16  SDRAM byte address
- ROM_DATA  in  8  SDRAM data
- ROM_OK  in  1  SDRAM data valid

Behaviour:
- Reset values:
  - ROM_CS=0, ROM_ADDR=0, REQ_DATA=0, REQ_OK=0.
  - All per-channel valid flags=0; grant pointer=0; FSM=IDLE.
  - Bank register k of every channel = k, giving a linear mapping at boot.
- Reset is asynchronous and takes effect mid-fetch with no ROM_CS glitch beyond the reset edge.
- Bank write: when BANK_WE=1 and BANK_SEL channel < CHANNELS, bank[ch][bank] <= BANK_DIN[BANK_W-1:0] next cycle. The same cycle also clears valid[ch], forcing a refetch. Writes to out-of-range channels are ignored.
- Mapping, linear: ROM_ADDR = {bank[ch][A[17:16]], A[15:0]}.
- Mapping, paged: when paging is active for ch and A < 0x400, ROM_ADDR = {bank[ch][A[9:8]], 6'b0, A[9:0]}.
- Per channel: keeps served_addr (18b), data (8b) and valid. REQ_OK[ch] = valid[ch] && served_addr[ch]==REQ_ADDR[ch], compared combinationally, so REQ_OK drops the same cycle the address changes.
- Pending[ch] = REQ_CS[ch] && !REQ_OK[ch].
- FSM:
  - IDLE: scan from the grant pointer for the first pending channel (round-robin). If found, latch ch and its request address, drive ROM_ADDR, set ROM_CS=1, go to ISSUE. Otherwise stay.
  - ISSUE: one-cycle guard; ROM_OK is ignored here (stale-ok protection). Go to WAIT.
  - WAIT: hold ROM_CS and ROM_ADDR stable. When ROM_OK=1: data[ch] <= ROM_DATA, served_addr[ch] <= latched address, valid[ch] <= 1, ROM_CS <= 0, grant pointer <= ch+1 mod CHANNELS, go to IDLE.
- Latency: request to REQ_OK is a minimum of 4 cycles (IDLE detect, ISSUE, WAIT with ROM_OK, registered valid).
- Address change during a fetch: the in-flight fetch completes with the latched address. The compare then fails, so the channel re-requests; no abort.
- Bank write during a fetch targeting the same channel: the in-flight fetch completes, but its valid set is suppressed, so the channel refetches with the new bank.
- Simultaneous pending channels: strict round-robin; no channel waits more than CHANNELS fetches.
- REQ_CS low: the channel is never granted. Its data and valid are retained.

Optional Feature:
- Macro: NMK112_PAGING_EN.
- Defined: channels whose PAGE_MASK bit is 1 use the table-region paging rule for A < 0x400.
- Not defined: all channels use linear mapping only; PAGE_MASK is unused, and the paging comparator and mux are not synthesised.

Test Plan:
- Reset, then ch0 REQ_CS=1, A=0x12345, ROM_OK returned 2 cycles after ROM_CS -> ROM_ADDR=0x012345 (bank1 default=1). REQ_OK[0] rises, REQ_DATA[0]=ROM_DATA.
- Write ch0 bank1=0x05, then request A=0x12345 -> ROM_ADDR=0x052345. Previous valid cleared; REQ_OK[0]=0 until refetch.
- With NMK112_PAGING_EN, PAGE_MASK=1: ch0 bank2=0x07, A=0x00234 -> ROM_ADDR=0x070234. Same stimulus without the macro -> ROM_ADDR=0x000234.
- ch0 and ch1 pending together, grant=0 -> ch0 served first, then ch1. With both re-requesting continuously, grants alternate 0,1,0,1.
- ROM_OK held high constantly -> first fetch completes only in WAIT, never in ISSUE (ROM_CS high for at least 2 cycles). Change REQ_ADDR[0] mid-WAIT -> stale data stored, REQ_OK[0] stays 0, second fetch issued for the new address.
- Assert RESET96_N=0 during WAIT -> ROM_CS=0 and REQ_OK=0 immediately. Bank registers return to identity.

Source files
------------

// File: rtl/nmk112_pcm_arbiter.sv
// NMK112-style PCM bank mapper and round-robin SDRAM fetch arbiter for up to four jt6295 engines.
// Optional table-region paging is compiled in with `define NMK112_PAGING_EN.
module nmk112_pcm_arbiter #(
    parameter int         CHANNELS  = 2,
    parameter int         BANK_W    = 5,
    parameter logic [3:0] PAGE_MASK = 4'b0001
) (
    input  logic                   CLK96,
    input  logic                   RESET96_N,
    input  logic                   BANK_WE,
    input  logic [3:0]             BANK_SEL,
    input  logic [7:0]             BANK_DIN,
    input  logic [CHANNELS-1:0]    REQ_CS,
    input  logic [CHANNELS*18-1:0] REQ_ADDR,
    output logic [CHANNELS*8-1:0]  REQ_DATA,
    output logic [CHANNELS-1:0]    REQ_OK,
    output logic                   ROM_CS,
    output logic [BANK_W+15:0]     ROM_ADDR,
    input  logic [7:0]             ROM_DATA,
    input  logic                   ROM_OK,
    output logic [1:0]             state_dbg
);
    localparam int ROM_AW = BANK_W + 16;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
    state_t state, state_nx;

    // Per-channel storage is sized for the maximum of four so 2-bit indices always fit.
    logic [BANK_W-1:0] bank [4][4];
    logic [17:0]       served_addr [4];
    logic [7:0]        data [4];
    logic [17:0]       req_addr [4];
    logic [3:0]        valid;
    logic [3:0]        pending;

    logic [1:0]        grant_ptr, cur_ch, pick_ch;
    logic [17:0]       cur_addr, pick_addr;
    logic              pick_found, kill, grant, done, wr_en;
    logic [ROM_AW-1:0] map_addr;
    logic [2:0]        idx;

    // Handshake: ROM_CS rises with ROM_ADDR already valid and both hold until the cycle
    // ROM_OK is sampled in WAIT; ROM_OK seen during ISSUE belongs to an older request.
    assign wr_en = BANK_WE && ({1'b0, BANK_SEL[3:2]} < 3'(CHANNELS));
    assign grant = (state == IDLE) && pick_found;
    assign done  = (state == WAIT) && ROM_OK;

    always_comb begin
        REQ_OK   = '0;
        REQ_DATA = '0;
        pending  = '0;
        for (int c = 0; c < 4; c++) req_addr[c] = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            req_addr[c]        = REQ_ADDR[c*18 +: 18];
            REQ_OK[c]          = valid[c] && (served_addr[c] == req_addr[c]);
            REQ_DATA[c*8 +: 8] = data[c];
            pending[c]         = REQ_CS[c] && !(valid[c] && (served_addr[c] == req_addr[c]));
        end
    end

    // Scan downwards so the candidate closest to the grant pointer is the one that sticks.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        pick_addr  = '0;
        idx        = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            idx = {1'b0, grant_ptr} + 3'(i);
            if (idx >= 3'(CHANNELS)) idx = idx - 3'(CHANNELS);
            if (pending[idx[1:0]]) begin
                pick_found = 1'b1;
                pick_ch    = idx[1:0];
                pick_addr  = req_addr[idx[1:0]];
            end
        end
    end

    always_comb begin
        map_addr = {bank[pick_ch][pick_addr[17:16]], pick_addr[15:0]};
`ifdef NMK112_PAGING_EN
        if (PAGE_MASK[pick_ch] && (pick_addr < 18'h400))
            map_addr = {bank[pick_ch][pick_addr[9:8]], 6'b0, pick_addr[9:0]};
`endif
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_found) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (ROM_OK) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ROM_CS    = (state != IDLE);
        state_dbg = state;
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            ROM_ADDR  <= '0;
            grant_ptr <= '0;
            cur_ch    <= '0;
            cur_addr  <= '0;
            kill      <= 1'b0;
            valid     <= '0;
            for (int c = 0; c < 4; c++) begin
                served_addr[c] <= '0;
                data[c]        <= '0;
                for (int k = 0; k < 4; k++) bank[c][k] <= BANK_W'(k);
            end
        end else begin
            if (wr_en) bank[BANK_SEL[3:2]][BANK_SEL[1:0]] <= BANK_DIN[BANK_W-1:0];

            // A bank write to the channel being fetched makes the fetched byte untrustworthy.
            if (grant) begin
                cur_ch   <= pick_ch;
                cur_addr <= pick_addr;
                ROM_ADDR <= map_addr;
                kill     <= wr_en && (BANK_SEL[3:2] == pick_ch);
            end else if ((state != IDLE) && wr_en && (BANK_SEL[3:2] == cur_ch)) begin
                kill <= 1'b1;
            end

            if (done) begin
                data[cur_ch]        <= ROM_DATA;
                served_addr[cur_ch] <= cur_addr;
                grant_ptr           <= (cur_ch == 2'(CHANNELS - 1)) ? 2'd0 : cur_ch + 2'd1;
                if (!kill && !(wr_en && (BANK_SEL[3:2] == cur_ch))) valid[cur_ch] <= 1'b1;
            end
            if (wr_en) valid[BANK_SEL[3:2]] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_nmk112_pcm_arbiter.sv
// Directed bench for nmk112_pcm_arbiter: SDRAM responder returns addr[7:0]+0x11,
// a grant monitor checks each issued ROM_ADDR against an expected queue.
module tb_nmk112_pcm_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        bank_we;
    logic [3:0]  bank_sel;
    logic [7:0]  bank_din;
    logic [1:0]  req_cs;
    logic [35:0] req_addr;
    logic [15:0] req_data;
    logic [1:0]  req_ok;
    logic        rom_cs;
    logic [20:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int ok_delay = 2;
    logic ok_always = 1'b0;
    int cs_age = 0;
    int cs_len = 0;
    int last_cs_len = 0;
    logic prev_cs = 1'b0;
    logic [20:0] exp_q[$];

    nmk112_pcm_arbiter #(.CHANNELS(2), .BANK_W(5), .PAGE_MASK(4'b0001)) dut (
        .CLK96(clk), .RESET96_N(rst_n), .BANK_WE(bank_we), .BANK_SEL(bank_sel),
        .BANK_DIN(bank_din), .REQ_CS(req_cs), .REQ_ADDR(req_addr), .REQ_DATA(req_data),
        .REQ_OK(req_ok), .ROM_CS(rom_cs), .ROM_ADDR(rom_addr), .ROM_DATA(rom_data),
        .ROM_OK(rom_ok), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rom_cs) cs_age++;
        else        cs_age = 0;
        rom_ok   = ok_always || (rom_cs && cs_age >= ok_delay);
        rom_data = rom_addr[7:0] + 8'h11;
    end

    always @(negedge clk) begin
        if (rom_cs && !prev_cs) begin
            check("grant_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("grant_addr", 32'(rom_addr), 32'(exp_q.pop_front()));
        end
        if (rom_cs) cs_len++;
        else if (prev_cs) begin
            last_cs_len = cs_len;
            cs_len = 0;
        end
        prev_cs = rom_cs;
    end

    task automatic bank_write(input logic [1:0] ch, input logic [1:0] bk, input logic [7:0] val);
        bank_we  = 1'b1;
        bank_sel = {ch, bk};
        bank_din = val;
        @(negedge clk);
        bank_we = 1'b0;
    endtask

    task automatic set_addr(input int ch, input logic [17:0] a);
        req_addr[ch*18 +: 18] = a;
    endtask

    task automatic wait_ok(input int ch, input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ok[ch]) break;
        end
        check(tag, 32'(req_ok[ch]), 1);
    endtask

    task automatic wait_cs_rise(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rom_cs) break;
        end
        check(tag, 32'(rom_cs), 1);
    endtask

    initial begin
        rst_n = 1'b0; bank_we = 1'b0; bank_sel = '0; bank_din = '0;
        req_cs = '0; req_addr = '0; rom_ok = 1'b0; rom_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rom_cs", 32'(rom_cs), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_req_ok", 32'(req_ok), 0);
        check("rst_req_data", 32'(req_data), 0);
        check("rst_state", 32'(state_dbg), 0);

        // Linear fetch with identity banks.
        exp_q.push_back(21'h012345);
        set_addr(0, 18'h12345);
        req_cs = 2'b01;
        wait_ok(0, "t1_ok");
        check("t1_data", 32'(req_data[7:0]), 32'h56);
        @(negedge clk);
        check("t1_cs_low", 32'(rom_cs), 0);
        check("t1_ok_held", 32'(req_ok[0]), 1);

        // Bank rewrite invalidates and refetches through the new bank.
        exp_q.push_back(21'h052345);
        bank_write(2'd0, 2'd1, 8'h05);
        check("t2_ok_cleared", 32'(req_ok[0]), 0);
        wait_ok(0, "t2_ok");
        check("t2_data", 32'(req_data[7:0]), 32'h56);

        // Idle channel keeps its data; out-of-range writes are dropped; paging region.
        req_cs = 2'b00;
        @(negedge clk);
        check("t3_retain", 32'(req_ok[0]), 1);
        bank_write(2'd2, 2'd0, 8'h1f);
        check("t3_oor_write", 32'(req_ok[0]), 1);
        bank_write(2'd0, 2'd2, 8'h07);
        check("t3_ok_cleared", 32'(req_ok[0]), 0);
`ifdef NMK112_PAGING_EN
        exp_q.push_back(21'h070234);
`else
        exp_q.push_back(21'h000234);
`endif
        set_addr(0, 18'h00234);
        req_cs = 2'b01;
        wait_ok(0, "t3_ok");
        check("t3_data", 32'(req_data[7:0]), 32'h45);

        // Round robin: prime ch1 so the pointer wraps to 0, then two contested rounds.
        exp_q.push_back(21'h030000);
        set_addr(1, 18'h30000);
        req_cs = 2'b11;
        wait_ok(1, "t4_prime_ok");
        exp_q.push_back(21'h070456);
        exp_q.push_back(21'h020878);
        set_addr(0, 18'h20456);
        set_addr(1, 18'h20878);
        wait_ok(1, "t4_r1_ok1");
        check("t4_r1_ok0", 32'(req_ok[0]), 1);
        check("t4_r1_data0", 32'(req_data[7:0]), 32'h67);
        check("t4_r1_data1", 32'(req_data[15:8]), 32'h89);
        exp_q.push_back(21'h030401);
        exp_q.push_back(21'h010999);
        set_addr(0, 18'h30401);
        set_addr(1, 18'h10999);
        wait_ok(1, "t4_r2_ok1");
        check("t4_r2_ok0", 32'(req_ok[0]), 1);
        check("t4_r2_data0", 32'(req_data[7:0]), 32'h12);
        check("t4_r2_data1", 32'(req_data[15:8]), 32'haa);

        // ROM_OK stuck high must not complete in ISSUE.
        ok_always = 1'b1;
        exp_q.push_back(21'h050010);
        set_addr(0, 18'h10010);
        wait_ok(0, "t5_ok");
        @(negedge clk);
        check("t5_cs_len", 32'(last_cs_len), 2);
        check("t5_data", 32'(req_data[7:0]), 32'h21);
        ok_always = 1'b0;
        ok_delay  = 3;
        @(negedge clk);

        // Address change mid-WAIT: stale byte stored, then refetch.
        exp_q.push_back(21'h050020);
        exp_q.push_back(21'h050030);
        set_addr(0, 18'h10020);
        wait_cs_rise("t6_cs_rise");
        @(negedge clk);
        set_addr(0, 18'h10030);
        repeat (2) @(negedge clk);
        check("t6_cs_done", 32'(rom_cs), 0);
        check("t6_stale_ok", 32'(req_ok[0]), 0);
        wait_ok(0, "t6_ok");
        check("t6_data", 32'(req_data[7:0]), 32'h41);

        // Bank write to the channel in flight suppresses its valid.
        exp_q.push_back(21'h050040);
        exp_q.push_back(21'h090040);
        set_addr(0, 18'h10040);
        wait_cs_rise("t7_cs_rise");
        bank_write(2'd0, 2'd1, 8'h09);
        repeat (2) @(negedge clk);
        check("t7_cs_done", 32'(rom_cs), 0);
        check("t7_killed_ok", 32'(req_ok[0]), 0);
        wait_ok(0, "t7_ok");
        check("t7_data", 32'(req_data[7:0]), 32'h51);

        // Asynchronous reset during WAIT.
        exp_q.push_back(21'h010abc);
        set_addr(1, 18'h10abc);
        wait_cs_rise("t8_cs_rise");
        @(negedge clk);
        check("t8_in_wait", 32'(state_dbg), 2);
        #2 rst_n = 1'b0;
        #1;
        check("t8_rst_cs", 32'(rom_cs), 0);
        check("t8_rst_ok", 32'(req_ok), 0);
        check("t8_rst_addr", 32'(rom_addr), 0);
        check("t8_rst_data", 32'(req_data), 0);
        check("t8_rst_state", 32'(state_dbg), 0);
        req_cs = 2'b01;
        @(negedge clk);
        exp_q.push_back(21'h010040);
        rst_n = 1'b1;
        wait_ok(0, "t8_identity_ok");
        check("t8_data", 32'(req_data[7:0]), 32'h51);

        repeat (2) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
